// File: rtl/ycr_clkgate_pkg.sv
// Shared types and defaults for the per-channel clock-gating controller.
package ycr_clkgate_pkg;

  localparam int NCH_DEF    = 4;
  localparam int IDLE_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } cg_state_e;

endpackage

// File: rtl/ycr_cg_cell.sv
// Latch-and-AND clock gate; behavioural stand-in for a library ICG cell.
module ycr_cg_cell (
  input  logic clk,
  input  logic en,
  input  logic test_mode,
  output logic clk_out
);

  logic en_l;

  // Transparent only while clk is low, so the enable cannot change mid high phase.
  always_latch begin
    if (!clk) en_l <= en | test_mode;
  end

  assign clk_out = clk & en_l;

endmodule

// File: rtl/ycr_clkgate_ctrl.sv
// Per-channel idle-driven clock gating with wake handshake and DFT override.
module ycr_clkgate_ctrl
  import ycr_clkgate_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int IDLE_W = IDLE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_mode,
  input  logic [IDLE_W-1:0] cfg_idle_thr,
  input  logic [NCH-1:0]    ch_busy,
  input  logic [NCH-1:0]    ch_force_on,
  input  logic [NCH-1:0]    ch_wake_req,
  output logic [NCH-1:0]    ch_wake_ack,
  output logic [NCH-1:0]    ch_gated,
  output logic [NCH-1:0]    clk_out
);

  logic [NCH-1:0] enable;
  logic           thr_zero;

  assign thr_zero = (cfg_idle_thr == '0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cg_state_e         state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic              act;
    logic              en_c;
    logic              gated_c;
    logic              ack_c;

    assign act = ch_busy[i] | ch_force_on[i] | ch_wake_req[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_ON;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Threshold is compared live, so lowering it mid-count gates on the next edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_c    = 1'b1;
      gated_c = 1'b0;
      ack_c   = 1'b0;
      unique case (state_q)
        ST_ON: begin
          ack_c = ch_wake_req[i];
          if (!act && !thr_zero) begin
            state_d = ST_COUNT;
            cnt_d   = IDLE_W'(1);
          end
        end
        ST_COUNT: begin
          ack_c = ch_wake_req[i];
          if (act || thr_zero) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (cnt_q >= cfg_idle_thr) begin
            state_d = ST_GATED;
          end else begin
            cnt_d = cnt_q + IDLE_W'(1);
          end
        end
        ST_GATED: begin
          en_c    = 1'b0;
          gated_c = 1'b1;
          if (act) state_d = ST_WAKE;
        end
        ST_WAKE: begin
          ack_c   = 1'b1;
          state_d = ST_ON;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      endcase
    end

    assign enable[i]      = en_c;
    assign ch_gated[i]    = gated_c;
    assign ch_wake_ack[i] = ack_c;

    ycr_cg_cell u_cg (
      .clk       (clk),
      .en        (enable[i]),
      .test_mode (test_mode),
      .clk_out   (clk_out[i])
    );
  end

endmodule
